// File: rtl/alu_pkg.sv
// alu_pkg: shared UART TX state encoding and frame constants
package alu_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO (clk, rst, push/din in, pop/dout out, full, empty, count)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/alu_result_uart_tx.sv
// alu_result_uart_tx: buffers ALU result bytes (res_valid/res_data/res_ready) and sends them as 8N1 frames on tx (busy, fifo_count, sticky overflow cleared by ovf_clr)
module alu_result_uart_tx
  import alu_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          res_valid,
  input  logic [7:0]                    res_data,
  output logic                          res_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  tx_state_t state, state_n;
  logic [BW-1:0] baud;
  logic [IW-1:0] bit_idx;
  logic [7:0] shreg, head;
  logic full, empty, push, pop, bit_done, last_bit;
  assign res_ready = !full;
  assign push = res_valid && res_ready && !rst;
  assign busy = state != IDLE;
  assign bit_done = baud == BW'(CLKS_PER_BIT - 1);
  assign last_bit = bit_idx == IW'(DATA_BITS - 1);
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(res_data),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  always_comb begin
    state_n = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = !empty;
        state_n = empty ? IDLE : START;
      end
      START: state_n = bit_done ? DATA : START;
      DATA: state_n = (bit_done && last_bit) ? STOP : DATA;
      STOP: begin
        pop = bit_done && !empty;
        state_n = !bit_done ? STOP : empty ? IDLE : START;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shreg <= '0;
      tx <= STOP_BIT;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      baud <= (state == IDLE || bit_done) ? '0 : baud + 1'b1;
      bit_idx <= state == DATA ? bit_idx + IW'(bit_done) : '0;
      overflow <= (res_valid && !res_ready) ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      if (pop) begin
        shreg <= head;
        tx <= START_BIT;
      end else if (bit_done && (state == START || (state == DATA && !last_bit))) begin
        tx <= shreg[0];
        shreg <= {1'b0, shreg[7:1]};
      end else if (bit_done) begin
        tx <= STOP_BIT;
      end
    end
  end
endmodule

// File: doc/alu_result_uart_tx.md
ALU_RESULT_UART_TX -- requirements
Module: alu_result_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per serial bit, legal range 2..1023.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: result buffer entries, power of two, 2..16.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port res_valid  input  1  ALU result on res_data is offered.
REQ-006 The block SHALL have port res_data  input  8  registered ALU result byte.
REQ-007 The block SHALL have port res_ready  output  1  buffer can accept a byte this cycle.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port busy  output  1  a frame is being transmitted.
REQ-010 The block SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes buffered, excluding the byte in flight.
REQ-011 The block SHALL have port overflow  output  1  sticky: a byte was offered while res_ready was low.
REQ-012 The block SHALL have port ovf_clr  input  1  clears overflow.

Function
REQ-013 A byte SHALL be accepted on a rising edge where res_valid and res_ready are both high; res_ready SHALL equal (fifo_count != FIFO_DEPTH), combinationally.
REQ-014 Accepted bytes SHALL be transmitted in acceptance order; none dropped, none duplicated.
REQ-015 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles; frame = 10*CLKS_PER_BIT cycles.
REQ-016 FSM states: IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty (pop on that edge); START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8th bit completes; STOP->START if FIFO non-empty at end of stop bit (pop, no idle gap), else STOP->IDLE.
REQ-017 Latency: byte accepted into empty FIFO with FSM in IDLE at edge N SHALL make tx low starting the cycle after edge N+1 (tx registered).
REQ-018 tx SHALL be driven from a register; no combinational path from any input to tx.
REQ-019 busy SHALL be high in START, DATA, STOP and low in IDLE.
REQ-020 Simultaneous push and pop on one edge SHALL leave fifo_count unchanged and keep both bytes correctly ordered.
REQ-021 Full: push blocked by res_ready low; a pop on the same edge does not make the push accepted that cycle (no ready-from-pop bypass).
REQ-022 Empty: no pop issued; FSM stays IDLE with tx high.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 overflow SHALL set on any edge with res_valid high and res_ready low; ovf_clr clears it; set wins when both occur on the same edge.
REQ-025 res_data SHALL be captured at acceptance; later changes do not affect the queued byte.

Reset
REQ-026 While rst is high at a rising edge: FSM->IDLE, FIFO flushed (fifo_count 0), bit/cycle counters 0, tx 1, busy 0, overflow 0, res_ready 1 the cycle after.
REQ-027 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 in the cycle after the reset edge, and the aborted byte is never resent.
REQ-028 No byte SHALL be accepted on an edge where rst is high.

Structure
REQ-029 Shared package alu_pkg SHALL hold the TX state enum and constants START_BIT=0, STOP_BIT=1, DATA_BITS=8.
REQ-030 Buffering SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count); FSM, baud counter, shift register in alu_result_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Push 0xA5 once from idle -> tx: 4 cycles 0, bits 1,0,1,0,0,1,0,1 each 4 cycles, 4 cycles 1; busy high 40 cycles; fifo_count 1 then 0.
REQ-032 Push 0x01,0x02,0x03 back-to-back -> three contiguous 40-cycle frames, no idle cycle between, correct order.
REQ-033 Push 6 bytes with res_valid held high from idle -> 5 accepted (1 in flight + 4 buffered), res_ready low while full, overflow set; ovf_clr -> overflow 0.
REQ-034 Push while FIFO has 3 entries on the edge the FSM pops -> fifo_count stays 3, all bytes emitted in order.
REQ-035 Assert rst at cycle 15 of a 0xFF frame with 2 bytes queued -> tx 1 next cycle, busy 0, fifo_count 0, no further frames.
REQ-036 Change res_data every cycle after acceptance of 0x3C -> transmitted byte is 0x3C.
